// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential chunked comparator: op codes, FSM states,
// and helpers that decode an op into its final outcome.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LT  = 3'b010,
        OP_LTU = 3'b011,
        OP_GE  = 3'b100,
        OP_GEU = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'b101;
    endfunction

    // Only the MSB chunk of the signed ops carries a sign bit.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == 3'(OP_LT)) || (op == 3'(OP_GE));
    endfunction

    // Outcome once the deciding chunk has been reached.
    function automatic logic op_result(input logic [2:0] op, input logic eq, input logic lt);
        logic r;
        case (op)
            3'(OP_EQ):                   r = eq;
            3'(OP_NE):                   r = !eq;
            3'(OP_LT), 3'(OP_LTU):       r = lt;
            3'(OP_GE), 3'(OP_GEU):       r = !lt;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational compare of one CHUNK-wide slice, optionally as signed values.
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             signed_en,
    output logic             eq,
    output logic             lt
);

    always_comb begin
        eq = (a == b);
        lt = signed_en ? ($signed(a) < $signed(b)) : (a < b);
    end

endmodule

// File: rtl/seq_compare.sv
// Multi-cycle comparator: walks the operands one chunk per cycle, MSB chunk
// first, and stops at the first differing chunk or at chunk 0.
module seq_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             out_err,
    output state_e           dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              res_q, res_d, err_q, err_d;

    logic [CHUNK-1:0]  a_ch, b_ch;
    logic              c_eq, c_lt, c_signed;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign c_signed = (idx_q == LAST_IDX) && is_signed_op(op_q);

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a         (a_ch),
        .b         (b_ch),
        .signed_en (c_signed),
        .eq        (c_eq),
        .lt        (c_lt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_BUSY;
                    idx_d   = LAST_IDX;
                    op_d    = op;
                    a_d     = in0;
                    b_d     = in1;
                    res_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (!is_legal_op(op_q)) begin
                    state_d = ST_DONE;
                    res_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (!c_eq || (idx_q == '0)) begin
                    state_d = ST_DONE;
                    res_d   = op_result(op_q, c_eq, c_lt);
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= LAST_IDX;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign out_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_compare.sv
// Directed bench for seq_compare (WIDTH=32, CHUNK=8) with hand-computed results.
module tb_seq_compare;
    import cmp_pkg::*;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        out_valid;
    logic        out_ready;
    logic        result;
    logic        out_err;
    state_e      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    seq_compare #(.WIDTH(32), .CHUNK(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_err   (out_err),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at the falling edge; it is accepted on the next rising edge.
    // Afterwards the inputs are scrambled so any late sampling shows up.
    task automatic start_op(input string tag, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        op       = o;
        in0      = a;
        in1      = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        in0      = $urandom;
        in1      = $urandom;
    endtask

    task automatic wait_result(input string tag, input int exp_m);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_m));
    endtask

    task automatic finish_op(input string tag, input logic exp_res,
                             input logic exp_err, input int exp_m);
        wait_result(tag, exp_m);
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        in0       = '0;
        in1       = '0;
        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clock);
        resetn = 1'b1;

        start_op("eq_dead", 3'b000, 32'hDEADBEEF, 32'hDEADBEEF);
        finish_op("eq_dead", 1'b1, 1'b0, 4);
        start_op("lt_sign", 3'b010, 32'h80000000, 32'h00000001);
        finish_op("lt_sign", 1'b1, 1'b0, 1);
        start_op("ltu_sign", 3'b011, 32'h80000000, 32'h00000001);
        finish_op("ltu_sign", 1'b0, 1'b0, 1);
        start_op("geu_lsb", 3'b101, 32'h12345678, 32'h12345679);
        finish_op("geu_lsb", 1'b0, 1'b0, 4);
        start_op("ne_lsb", 3'b001, 32'h12345678, 32'h12345679);
        finish_op("ne_lsb", 1'b1, 1'b0, 4);
        start_op("ill_111", 3'b111, 32'h00000005, 32'h00000005);
        finish_op("ill_111", 1'b0, 1'b1, 1);
        start_op("eq_after_ill", 3'b000, 32'h0000AA55, 32'h0000AA55);
        finish_op("eq_after_ill", 1'b1, 1'b0, 4);
        start_op("ge_neg", 3'b100, 32'hFFFFFFFF, 32'h00000001);
        finish_op("ge_neg", 1'b0, 1'b0, 1);
        // Second chunk is compared unsigned: 0xFF > 0x01.
        start_op("lt_mid", 3'b010, 32'h12FF0000, 32'h12010000);
        finish_op("lt_mid", 1'b0, 1'b0, 2);
        start_op("eq_diff", 3'b000, 32'h11223344, 32'h11223345);
        finish_op("eq_diff", 1'b0, 1'b0, 4);
        start_op("ill_110", 3'b110, 32'h00000001, 32'h00000002);
        finish_op("ill_110", 1'b0, 1'b1, 1);
        start_op("ge_equal", 3'b100, 32'hAAAAAAAA, 32'hAAAAAAAA);
        finish_op("ge_equal", 1'b1, 1'b0, 4);

        // out_ready held high while busy must not cut the operation short.
        out_ready = 1'b1;
        start_op("ltu_c1", 3'b011, 32'h00000100, 32'h00000200);
        out_ready = 1'b1;
        wait_result("ltu_c1", 3);
        chk("ltu_c1_result", 32'(result), 32'd1);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("ltu_c1_drained", 32'(in_ready), 32'd1);

        // Stall in DONE with extra requests arriving.
        start_op("stall", 3'b000, 32'h00000005, 32'h00000005);
        wait_result("stall", 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            op       = 3'($urandom_range(0, 7));
            in0      = $urandom;
            in1      = $urandom;
            @(posedge clock);
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", 32'(result), 32'd1);
            chk("stall_err", 32'(out_err), 32'd0);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("release_idle", 32'(dbg_state), 32'(ST_IDLE));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("release_no_accept", 32'(in_ready), 32'd1);

        // Reset mid-BUSY discards the op; the first edge after release accepts.
        start_op("rst_busy", 3'b000, 32'h00000001, 32'h00000001);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_busy_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_busy_ready", 32'(in_ready), 32'd1);
        chk("rst_busy_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        resetn   = 1'b1;
        op       = 3'b101;
        in0      = 32'h00000005;
        in1      = 32'h00000003;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("first_accept", 32'(dbg_state), 32'(ST_BUSY));
        finish_op("geu_post_rst", 1'b1, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
